// File: rtl/reg_arb_pkg.sv
// Shared constants and helpers for the round-robin register-write arbiter.
package reg_arb_pkg;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;
    localparam int MAX_REQ     = 8;

    // A single requester would still need a 1-bit owner field.
    function automatic int own_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic logic [MAX_REQ-1:0] onehot(input int idx);
        logic [MAX_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotated-priority scan: first set req bit starting at ptr, wrapping.
module rr_pick
    import reg_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int OWN_W   = own_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWN_W-1:0]   ptr,
    output logic               any,
    output logic [OWN_W-1:0]   winner
);

    int   idx;
    logic found;

    // Modulo is done by subtraction so idx never leaves 0..NUM_REQ-1.
    always_comb begin
        any    = |req;
        winner = '0;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = OWN_W'(idx);
            end
        end
    end

endmodule

// File: rtl/reg_wr_arbiter.sv
// Round-robin arbiter that shares one DATA_W-bit register among NUM_REQ writers,
// reporting the granted requester and the last owner of the register.
module reg_wr_arbiter
    import reg_arb_pkg::*;
#(
    parameter  int NUM_REQ = NUM_REQ_DEF,
    parameter  int DATA_W  = DATA_W_DEF,
    localparam int OWN_W   = own_w(NUM_REQ)
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      clr,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] wdata,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         Q,
    output logic                      q_valid,
    output logic [OWN_W-1:0]          owner
);

    logic [OWN_W-1:0]   ptr_q, ptr_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic [OWN_W-1:0]   owner_q, owner_d;
    logic               vld_q, vld_d;

    logic               any;
    logic [OWN_W-1:0]   win;
    logic [DATA_W-1:0]  win_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .OWN_W   (OWN_W)
    ) u_pick (
        .req    (req),
        .ptr    (ptr_q),
        .any    (any),
        .winner (win)
    );

    assign win_data = wdata[int'(win)*DATA_W +: DATA_W];

    // clr outranks any request: the register empties and nobody is granted.
    always_comb begin
        ptr_d   = ptr_q;
        gnt_d   = '0;
        q_d     = q_q;
        owner_d = owner_q;
        vld_d   = vld_q;
        if (clr) begin
            q_d   = '0;
            vld_d = 1'b0;
        end else if (any) begin
            gnt_d   = NUM_REQ'(onehot(int'(win)));
            q_d     = win_data;
            owner_d = win;
            vld_d   = 1'b1;
            ptr_d   = (int'(win) == NUM_REQ - 1) ? '0 : win + 1'b1;
        end
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ptr_q   <= '0;
            gnt_q   <= '0;
            q_q     <= '0;
            owner_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            q_q     <= q_d;
            owner_q <= owner_d;
            vld_q   <= vld_d;
        end
    end

    assign gnt     = gnt_q;
    assign Q       = q_q;
    assign q_valid = vld_q;
    assign owner   = owner_q;

endmodule
